param_counter: RTL and testbench
================================

// Module: param_counter
// PURPOSE
//  Parametrised up/down modulo counter; generalises the fixed 4-bit free-running counter.
//  Adds configurable width and modulus, direction control, synchronous load/clear, and an enable prescaler.
//  Adds wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
//  Used as the general timer/event-count primitive feeding control FSMs in later projects.
// PARAMETERS
//  WIDTH     4   counter width in bits (1..32)
//  MODULUS   16  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  SATURATE  0   0 = wrap at boundary, 1 = hold at boundary
//  PRESCALE  1   enabled cycles per count step (1..65535); 1 = step on every enabled cycle
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  en        in   1      count enable; advances the prescaler
//  up        in   1      direction: 1 = increment, 0 = decrement
//  clear     in   1      synchronous clear to 0
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value to load
//  ovf_clr   in   1      clears the sticky ovf flag
//  cnt       out  WIDTH  current count (registered)
//  tc        out  1      one-cycle terminal-count pulse (registered)
//  ovf       out  1      sticky boundary-hit flag (registered)
// BEHAVIOUR
//  - MAX = MODULUS-1. All outputs are registered; updates occur on the rising edge of clk.
//  - Reset (rst=1): cnt=0, tc=0, ovf=0, prescaler=0. Reset overrides all other inputs and applies mid-operation.
//  - Priority per cycle: rst > clear > load > counting step.
//  - clear: cnt=0, prescaler=0, tc=0. ovf is unchanged.
//  - load: cnt=load_val, or MAX when load_val>MAX (clamp). Sets prescaler=0 and tc=0. ovf is unchanged.
//  - Prescaler state pre is 0..PRESCALE-1 and advances only when en=1.
//  - Step condition: en=1 && pre==PRESCALE-1. On a step, pre returns to 0; otherwise pre increments.
//  - en=0 freezes cnt and pre, and drives tc=0.
//  - Step when up=1:
//      cnt<MAX                 -> cnt+1
//      cnt==MAX, SATURATE=0    -> cnt=0
//      cnt==MAX, SATURATE=1    -> cnt stays MAX
//  - Step when up=0:
//      cnt>0                   -> cnt-1
//      cnt==0, SATURATE=0      -> cnt=MAX
//      cnt==0, SATURATE=1      -> cnt stays 0
//  - Boundary event: a step taken from MAX with up=1, or from 0 with up=0.
//  - On a boundary event: tc=1 for exactly the following cycle (aligned with the new cnt) and ovf is set.
//  - In saturate mode, tc pulses again on every further step while held at the boundary.
//  - ovf_clr clears ovf. If a boundary event and ovf_clr occur in the same cycle, set wins (ovf=1).
//  - Changing up mid-prescale does not reset pre. Direction is sampled only on the step cycle.
//  - Arithmetic is modulo MODULUS, never modulo 2**WIDTH. cnt never exceeds MAX.
//  - No combinational path from inputs to outputs.
// TESTING
//  - Default params; rst 1 cycle, en=1, up=1 for 17 cycles:
//      cnt runs 0..15 then 0; tc=1 only in the cycle cnt returns to 0; ovf=1 from then on.
//  - MODULUS=10, up=0 from reset:
//      first step gives cnt=9 with tc=1; the following 9 steps give 8..0 with tc=0.
//  - SATURATE=1, MODULUS=10, load 7, then up=1 for 5 steps:
//      cnt 8,9,9,9,9; tc=1 on the 3rd, 4th and 5th step results.
//  - PRESCALE=3, en=1, up=1:
//      cnt increments every 3rd cycle; after 2 en cycles drop en for 4 cycles, then raise it;
//      the step occurs on the next en cycle (pre was held).
//  - MODULUS=10, load_val=13 with load=1 and clear=1 together:
//      cnt=0 (clear wins); next cycle load alone gives cnt=9 (clamped).
//  - Set ovf; assert ovf_clr together with a boundary event -> ovf stays 1.
//  - ovf_clr alone -> ovf=0.
//  - rst mid-count at cnt=5 with pre=1 -> next cycle cnt=0, tc=0, ovf=0, and the next step needs PRESCALE enabled cycles.

Source files
------------

// File: rtl/param_counter.sv
// Parametrised up/down modulo counter with prescaler, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow flag.
module param_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULUS - 64'd1);
    localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0]      pre;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             boundary;
    logic [WIDTH-1:0] cnt_step;
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        step     = en && (pre == PRE_LAST);
        at_max   = (cnt == MAX);
        at_zero  = (cnt == '0);
        // Boundary only counts when the step is not pre-empted by clear/load.
        boundary = step && !clear && !load && (up ? at_max : at_zero);

        cnt_step = cnt;
        if (up) begin
            if (!at_max)
                cnt_step = cnt + WIDTH'(1);
            else if (!SATURATE)
                cnt_step = '0;
        end else begin
            if (!at_zero)
                cnt_step = cnt - WIDTH'(1);
            else if (!SATURATE)
                cnt_step = MAX;
        end

        load_clamped = (load_val > MAX) ? MAX : load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pre <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            // Set beats clear when both land in the same cycle.
            if (boundary)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;

            if (clear) begin
                cnt <= '0;
                pre <= '0;
                tc  <= 1'b0;
            end else if (load) begin
                cnt <= load_clamped;
                pre <= '0;
                tc  <= 1'b0;
            end else if (en) begin
                if (step) begin
                    cnt <= cnt_step;
                    pre <= '0;
                    tc  <= boundary;
                end else begin
                    pre <= pre + 16'd1;
                    tc  <= 1'b0;
                end
            end else begin
                tc <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: four instances cover default, modulo-10
// down-count, saturate mode and prescaled operation.
module tb_param_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a: defaults, b: MODULUS=10, c: saturate MODULUS=10, d: PRESCALE=3
    logic       a_rst, a_en, a_up, a_clear, a_load, a_ovf_clr, a_tc, a_ovf;
    logic [3:0] a_load_val, a_cnt;
    logic       b_rst, b_en, b_up, b_clear, b_load, b_ovf_clr, b_tc, b_ovf;
    logic [3:0] b_load_val, b_cnt;
    logic       c_rst, c_en, c_up, c_clear, c_load, c_ovf_clr, c_tc, c_ovf;
    logic [3:0] c_load_val, c_cnt;
    logic       d_rst, d_en, d_up, d_clear, d_load, d_ovf_clr, d_tc, d_ovf;
    logic [3:0] d_load_val, d_cnt;

    param_counter u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .clear(a_clear), .load(a_load),
        .load_val(a_load_val), .ovf_clr(a_ovf_clr), .cnt(a_cnt), .tc(a_tc), .ovf(a_ovf)
    );

    param_counter #(.WIDTH(4), .MODULUS(10)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .clear(b_clear), .load(b_load),
        .load_val(b_load_val), .ovf_clr(b_ovf_clr), .cnt(b_cnt), .tc(b_tc), .ovf(b_ovf)
    );

    param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .clear(c_clear), .load(c_load),
        .load_val(c_load_val), .ovf_clr(c_ovf_clr), .cnt(c_cnt), .tc(c_tc), .ovf(c_ovf)
    );

    param_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_d (
        .clk(clk), .rst(d_rst), .en(d_en), .up(d_up), .clear(d_clear), .load(d_load),
        .load_val(d_load_val), .ovf_clr(d_ovf_clr), .cnt(d_cnt), .tc(d_tc), .ovf(d_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int c, input int t, input int o);
        check({tag, ".cnt"}, 32'(a_cnt), c);
        check({tag, ".tc"},  32'(a_tc),  t);
        check({tag, ".ovf"}, 32'(a_ovf), o);
    endtask

    task automatic chk_b(input string tag, input int c, input int t, input int o);
        check({tag, ".cnt"}, 32'(b_cnt), c);
        check({tag, ".tc"},  32'(b_tc),  t);
        check({tag, ".ovf"}, 32'(b_ovf), o);
    endtask

    task automatic chk_c(input string tag, input int c, input int t, input int o);
        check({tag, ".cnt"}, 32'(c_cnt), c);
        check({tag, ".tc"},  32'(c_tc),  t);
        check({tag, ".ovf"}, 32'(c_ovf), o);
    endtask

    task automatic chk_d(input string tag, input int c, input int t, input int o);
        check({tag, ".cnt"}, 32'(d_cnt), c);
        check({tag, ".tc"},  32'(d_tc),  t);
        check({tag, ".ovf"}, 32'(d_ovf), o);
    endtask

    int sat_cnt[5] = '{8, 9, 9, 9, 9};
    int sat_tc[5]  = '{0, 0, 1, 1, 1};

    initial begin
        {a_en, a_up, a_clear, a_load, a_ovf_clr} = '0; a_load_val = '0; a_rst = 1'b1;
        {b_en, b_up, b_clear, b_load, b_ovf_clr} = '0; b_load_val = '0; b_rst = 1'b1;
        {c_en, c_up, c_clear, c_load, c_ovf_clr} = '0; c_load_val = '0; c_rst = 1'b1;
        {d_en, d_up, d_clear, d_load, d_ovf_clr} = '0; d_load_val = '0; d_rst = 1'b1;
        tick();
        chk_a("a_reset", 0, 0, 0);
        chk_b("b_reset", 0, 0, 0);
        chk_c("c_reset", 0, 0, 0);
        chk_d("d_reset", 0, 0, 0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;

        // Default counter: 17 up steps wraps 15 -> 0 once.
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk_a($sformatf("a_up%0d", i), i % 16, (i == 16) ? 1 : 0, (i >= 16) ? 1 : 0);
        end
        for (int i = 0; i < 14; i++) tick();
        check("a_pre_bnd.cnt", 32'(a_cnt), 15);
        a_ovf_clr = 1'b1;
        tick();
        chk_a("a_set_wins", 0, 1, 1);
        a_en = 1'b0;
        tick();
        chk_a("a_ovf_clr", 0, 0, 0);
        a_ovf_clr = 1'b0;

        // MODULUS=10 counting down from reset.
        b_en = 1'b1; b_up = 1'b0;
        tick();
        chk_b("b_dn_first", 9, 1, 1);
        for (int i = 8; i >= 0; i--) begin
            tick();
            chk_b($sformatf("b_dn%0d", i), i, 0, 1);
        end
        b_en = 1'b0; b_load_val = 4'd13; b_load = 1'b1; b_clear = 1'b1;
        tick();
        chk_b("b_clear_wins", 0, 0, 1);
        b_clear = 1'b0;
        tick();
        chk_b("b_load_clamp", 9, 0, 1);
        b_load = 1'b0;

        // Saturate mode: load 7 then climb into MAX and hold.
        c_load_val = 4'd7; c_load = 1'b1;
        tick();
        chk_c("c_load7", 7, 0, 0);
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_c($sformatf("c_sat%0d", i + 1), sat_cnt[i], sat_tc[i], (i >= 2) ? 1 : 0);
        end
        c_up = 1'b0;
        tick();
        chk_c("c_sat_down", 8, 0, 1);
        c_en = 1'b0;

        // PRESCALE=3: step every 3rd enabled cycle, pre held while en=0.
        d_en = 1'b1; d_up = 1'b1;
        tick(); check("d_pre1.cnt", 32'(d_cnt), 0);
        tick(); check("d_pre2.cnt", 32'(d_cnt), 0);
        tick(); chk_d("d_step1", 1, 0, 0);
        tick(); tick();
        check("d_two_en.cnt", 32'(d_cnt), 1);
        d_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_d($sformatf("d_hold%0d", i), 1, 0, 0);
        end
        d_en = 1'b1;
        tick();
        chk_d("d_resume", 2, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        check("d_mid.cnt", 32'(d_cnt), 5);
        d_rst = 1'b1;
        tick();
        chk_d("d_mid_rst", 0, 0, 0);
        d_rst = 1'b0;
        tick(); check("d_post1.cnt", 32'(d_cnt), 0);
        tick(); check("d_post2.cnt", 32'(d_cnt), 0);
        tick(); check("d_post3.cnt", 32'(d_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
